// File: rtl/fpga_data_source.sv
// CSR-loaded byte buffer streamed out as one AXI4-Stream packet per GO command.
// Optional FPGA_DATA_SOURCE_PATTERN_EN adds a SEED-based counting pattern in place of the buffer.
module fpga_data_source #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    avs_address,
  input  logic          avs_chipselect,
  input  logic          avs_write_n,
  input  logic [31:0]   avs_writedata,
  output logic [31:0]   avs_readdata,
  output logic [DW-1:0] axis4_m_tdata,
  output logic          axis4_m_tvalid,
  output logic          axis4_m_tlast,
  input  logic          axis4_m_tready
);

  typedef enum logic [1:0] {StIdle, StFetch, StStream} state_e;

  state_e        state_q;
  logic          go_q, load_q, pat_q;
  logic [AW-1:0] load_addr_q;
  logic [7:0]    load_data_q;
  logic [AW:0]   len_q, plen_q, cnt_q;
  logic [AW-1:0] idx_q;
  logic          done_q, overrun_q, len_err_q;
  logic [DW-1:0] mem [DEPTH];

  logic          csr_wr, ctrl_wr, busy, cmd_reject;
  logic [AW:0]   len_sat;
  logic [AW-1:0] rd_idx;
  logic [DW-1:0] beat_byte;
  logic          unused_wdata;

`ifdef FPGA_DATA_SOURCE_PATTERN_EN
  logic [7:0]    seed_q, pseed_q;
  logic          pat_mode_q;
`endif

  assign csr_wr       = avs_chipselect && !avs_write_n;
  assign ctrl_wr      = csr_wr && (avs_address == 2'd0);
  assign busy         = (state_q != StIdle);
  assign cmd_reject   = ctrl_wr && busy && (avs_writedata[0] || avs_writedata[1]);
  assign len_sat      = (len_q > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len_q;
  assign unused_wdata = ^avs_writedata;

  // Fetch presents beat 0; in stream the next beat is prepared for the accept edge.
  assign rd_idx = (state_q == StStream) ? idx_q + 1'b1 : idx_q;

  always_comb begin
    beat_byte = mem[rd_idx];
`ifdef FPGA_DATA_SOURCE_PATTERN_EN
    if (pat_mode_q) beat_byte = DW'(pseed_q + 8'(rd_idx));
`endif
  end

  // Buffer has no reset so its contents survive a mid-packet reset.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && load_q) mem[load_addr_q] <= DW'(load_data_q);
  end

  always_comb begin
    avs_readdata = '0;
    case (avs_address)
      2'd0: begin
        avs_readdata[0]       = go_q;
        avs_readdata[1]       = load_q;
        avs_readdata[3]       = pat_q;
        avs_readdata[8 +: AW] = load_addr_q;
        avs_readdata[23:16]   = load_data_q;
      end
      2'd1: begin
        avs_readdata[0]         = busy;
        avs_readdata[1]         = done_q;
        avs_readdata[2]         = overrun_q;
        avs_readdata[3]         = len_err_q;
        avs_readdata[8 +: AW+1] = cnt_q;
      end
      2'd2: avs_readdata[AW:0] = len_q;
      default: begin
`ifdef FPGA_DATA_SOURCE_PATTERN_EN
        avs_readdata[7:0] = seed_q;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      go_q           <= 1'b0;
      load_q         <= 1'b0;
      pat_q          <= 1'b0;
      load_addr_q    <= '0;
      load_data_q    <= '0;
      len_q          <= '0;
      plen_q         <= '0;
      cnt_q          <= '0;
      idx_q          <= '0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
      len_err_q      <= 1'b0;
      axis4_m_tdata  <= '0;
      axis4_m_tvalid <= 1'b0;
      axis4_m_tlast  <= 1'b0;
`ifdef FPGA_DATA_SOURCE_PATTERN_EN
      seed_q         <= '0;
      pseed_q        <= '0;
      pat_mode_q     <= 1'b0;
`endif
    end else begin
      if (ctrl_wr && !cmd_reject) begin
        go_q        <= avs_writedata[0];
        load_q      <= avs_writedata[1];
        pat_q       <= avs_writedata[3];
        load_addr_q <= avs_writedata[8 +: AW];
        load_data_q <= avs_writedata[23:16];
      end else if (state_q == StIdle) begin
        go_q   <= 1'b0;
        load_q <= 1'b0;
      end
      if (cmd_reject) overrun_q <= 1'b1;
      if (csr_wr && avs_address == 2'd2) len_q <= avs_writedata[AW:0];
`ifdef FPGA_DATA_SOURCE_PATTERN_EN
      if (csr_wr && avs_address == 2'd3) seed_q <= avs_writedata[7:0];
`endif

      case (state_q)
        StIdle: begin
          if (go_q) begin
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            len_err_q <= 1'b0;
            if (len_q == '0) begin
              len_err_q <= 1'b1;
            end else begin
              cnt_q   <= '0;
              idx_q   <= '0;
              plen_q  <= len_sat;
              state_q <= StFetch;
`ifdef FPGA_DATA_SOURCE_PATTERN_EN
              pat_mode_q <= pat_q;
              pseed_q    <= seed_q;
`endif
            end
          end
        end
        StFetch: begin
          axis4_m_tvalid <= 1'b1;
          axis4_m_tdata  <= beat_byte;
          axis4_m_tlast  <= (plen_q == (AW+1)'(1));
          state_q        <= StStream;
        end
        StStream: begin
          if (axis4_m_tready) begin
            cnt_q <= cnt_q + 1'b1;
            if (axis4_m_tlast) begin
              axis4_m_tvalid <= 1'b0;
              axis4_m_tlast  <= 1'b0;
              axis4_m_tdata  <= '0;
              done_q         <= 1'b1;
              state_q        <= StIdle;
            end else begin
              idx_q         <= idx_q + 1'b1;
              axis4_m_tdata <= beat_byte;
              axis4_m_tlast <= ({1'b0, idx_q} + (AW+1)'(2) == plen_q);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_data_source.sv
// Scoreboard bench for fpga_data_source: directed CSR programs, expected beats queued,
// a negedge monitor pops and compares every accepted beat and checks stall stability.
module tb_fpga_data_source;

  logic        clk, reset_n;
  logic [1:0]  avs_address;
  logic        avs_chipselect, avs_write_n;
  logic [31:0] avs_writedata, avs_readdata;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tready;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  logic [8:0] sb[$];

  fpga_data_source dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avs_address    (avs_address),
    .avs_chipselect (avs_chipselect),
    .avs_write_n    (avs_write_n),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .axis4_m_tdata  (tdata),
    .axis4_m_tvalid (tvalid),
    .axis4_m_tlast  (tlast),
    .axis4_m_tready (tready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: compare accepted beats against the scoreboard, verify held beats during stalls.
  initial begin
    logic       stall;
    logic [8:0] held, exp;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          n_cmp++;
          if (!(tvalid === 1'b1 && {tlast, tdata} === held)) begin
            n_err++;
            $display("FAIL stall_hold: got v=%0b beat=0x%0h, required v=1 beat=0x%0h",
                     tvalid, {tlast, tdata}, held);
          end
        end
        if (tvalid && tready) begin
          n_acc++;
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL extra_beat: got beat 0x%0h, required no beat", {tlast, tdata});
          end else begin
            exp = sb.pop_front();
            if ({tlast, tdata} !== exp) begin
              n_err++;
              $display("FAIL beat: got last/data 0x%0h, required 0x%0h", {tlast, tdata}, exp);
            end
          end
        end
        stall = tvalid && !tready;
        held  = {tlast, tdata};
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    avs_address    = a;
    avs_writedata  = d;
    avs_chipselect = 1'b1;
    avs_write_n    = 1'b0;
    @(posedge clk);
    #1;
    avs_chipselect = 1'b0;
    avs_write_n    = 1'b1;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    #1;
    d = avs_readdata;
  endtask

  task automatic wait_done(input string name);
    logic [31:0] s;
    bit ok;
    ok = 1'b0;
    cycles(2);
    for (int i = 0; i < 200; i++) begin
      csr_read(2'd1, s);
      if (s[1] && !s[0]) begin
        ok = 1'b1;
        break;
      end
      cycles(1);
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done, required done within 200 cycles", name);
    end
  endtask

  function automatic logic [7:0] fill(input int i);
    return 8'(i * 7 + 3);
  endfunction

  initial begin
    logic [31:0] r;
    logic [3:0]  tr_pat;
    logic        exp_v [7];
    logic        exp_l [7];
    int          base;
    bit          ok;

    reset_n = 1'b0;
    avs_address = '0;
    avs_chipselect = 1'b0;
    avs_write_n = 1'b1;
    avs_writedata = '0;
    tready = 1'b0;
    cycles(2);
    check("rst_tvalid", {31'b0, tvalid}, 32'd0);
    check("rst_tlast", {31'b0, tlast}, 32'd0);
    check("rst_tdata", {24'b0, tdata}, 32'd0);
    reset_n = 1'b1;
    cycles(1);
    csr_read(2'd0, r); check("rst_ctrl", r, 32'h0);
    csr_read(2'd1, r); check("rst_stat", r, 32'h0);
    csr_read(2'd2, r); check("rst_len", r, 32'h0);
    csr_read(2'd3, r); check("rst_seed", r, 32'h0);

    // 1: four loaded bytes, back-to-back, exact launch latency
    tready = 1'b1;
    csr_write(2'd2, 32'd4);
    for (int i = 0; i < 4; i++) csr_write(2'd0, {8'h0, 8'hA0 + 8'(i), 3'b0, 5'(i), 8'h02});
    for (int i = 0; i < 4; i++) sb.push_back({(i == 3), 8'hA0 + 8'(i)});
    exp_v = '{0, 0, 1, 1, 1, 1, 0};
    exp_l = '{0, 0, 0, 0, 0, 1, 0};
    csr_write(2'd0, 32'h1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("t1_tvalid_%0d", i), {31'b0, tvalid}, {31'b0, exp_v[i]});
      check($sformatf("t1_tlast_%0d", i), {31'b0, tlast}, {31'b0, exp_l[i]});
    end
    cycles(1);
    csr_read(2'd1, r); check("t1_stat", r, 32'h0402);

    // 2: tready pattern 1,0,0,1; done must track the 4th accept exactly
    tr_pat = 4'b1001;
    base = n_acc;
    for (int i = 0; i < 4; i++) sb.push_back({(i == 3), 8'hA0 + 8'(i)});
    csr_write(2'd0, 32'h1);
    cycles(1);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tready = tr_pat[i % 4];
      csr_read(2'd1, r);
      check("t2_done_vs_accepts", {31'b0, r[1]}, {31'b0, (n_acc - base) >= 4});
      if (r[1]) begin
        ok = 1'b1;
        break;
      end
      cycles(1);
    end
    check("t2_finished", {31'b0, ok}, 32'd1);
    tready = 1'b1;
    csr_read(2'd1, r); check("t2_stat", r, 32'h0402);

    // 3: zero length
    csr_write(2'd2, 32'd0);
    csr_write(2'd0, 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t3_no_tvalid", {31'b0, tvalid}, 32'd0);
    end
    cycles(1);
    csr_read(2'd1, r); check("t3_stat_flags", {28'b0, r[3:0]}, 32'h8);

    // 4: 32-beat packet; GO and LOAD while busy are rejected
    for (int i = 0; i < 32; i++) csr_write(2'd0, {8'h0, fill(i), 3'b0, 5'(i), 8'h02});
    csr_write(2'd2, 32'd32);
    for (int i = 0; i < 32; i++) sb.push_back({(i == 31), fill(i)});
    csr_write(2'd0, 32'h1);
    cycles(3);
    csr_write(2'd0, 32'h1);
    csr_write(2'd0, 32'h00EE_0202);
    wait_done("t4");
    cycles(5);
    csr_read(2'd1, r); check("t4_stat", r, 32'h2006);
    check("t4_sb_empty", sb.size(), 32'd0);

    // 5: reset on beat 5 of 10, then resend from mem[0]
    csr_write(2'd2, 32'd10);
    for (int i = 0; i < 5; i++) sb.push_back({1'b0, fill(i)});
    base = n_acc;
    csr_write(2'd0, 32'h1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (n_acc - base == 5) begin
        ok = 1'b1;
        break;
      end
    end
    check("t5_reached_beat5", {31'b0, ok}, 32'd1);
    check("t5_tvalid_before", {31'b0, tvalid}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("t5_tvalid_async", {31'b0, tvalid}, 32'd0);
    check("t5_tlast_async", {31'b0, tlast}, 32'd0);
    csr_read(2'd1, r); check("t5_stat_rst", r, 32'h0);
    cycles(1);
    reset_n = 1'b1;
    cycles(1);
    csr_write(2'd2, 32'd10);
    for (int i = 0; i < 10; i++) sb.push_back({(i == 9), fill(i)});
    csr_write(2'd0, 32'h1);
    wait_done("t5");
    csr_read(2'd1, r); check("t5_stat", r, 32'h0A02);

`ifdef FPGA_DATA_SOURCE_PATTERN_EN
    // 6: counting pattern wraps past 0xFF
    csr_write(2'd3, 32'hFE);
    csr_write(2'd2, 32'd3);
    sb.push_back({1'b0, 8'hFE});
    sb.push_back({1'b0, 8'hFF});
    sb.push_back({1'b1, 8'h00});
    csr_write(2'd0, 32'h9);
    wait_done("t6");
    csr_read(2'd1, r); check("t6_stat", r, 32'h0302);
    csr_read(2'd3, r); check("t6_seed", r, 32'hFE);
`else
    csr_write(2'd3, 32'hFE);
    csr_read(2'd3, r); check("t6_seed_dropped", r, 32'h0);
`endif

    cycles(5);
    check("final_sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
